serie_paralelo_rx: RTL and testbench
====================================

// Module: serie_paralelo_rx
// PURPOSE
//  Serial-to-parallel front end of PHY_RX. Deserialises one serial lane (MSB first).
//  Aligns to the comma byte COM (8'hBC) and declares link active after LOCK_COUNT aligned COMs.
//  Delivers one {byte, valid} word per 8 bit-times to the 2-lane-to-4-lane demux stage downstream.
//  One instance per lane.
// PARAMETERS
//  WIDTH       8      bits per symbol; shift register and data_out width
//  COMMA       8'hBC  idle/alignment symbol
//  LOCK_COUNT  4      consecutive aligned COMs required to enter ACTIVE (>=1)
// PORTS
//  clk_32f     in   1      bit clock; every rising edge samples one serial bit
//  reset       in   1      asynchronous, active-low; 0 = held in reset
//  data_in     in   1      serial data, MSB of each symbol first
//  data_out    out  WIDTH  deserialised symbol, registered
//  valid_out   out  1      1 = data_out is payload; 0 = idle (COM or not active)
//  byte_strobe out  1      one-cycle pulse when data_out/valid_out update (word boundary)
//  active      out  1      1 once LOCK_COUNT aligned COMs have been received; sticky until reset
// BEHAVIOUR
//  Reset (reset==0, async): data_out=0, valid_out=0, byte_strobe=0, active=0.
//   Also state=SEARCH, shift reg=0, bit_cnt=0, com_cnt=0. Release is sampled on the next clk_32f edge.
//  Every edge: sr_next = {sr[WIDTH-2:0], data_in}; sr <= sr_next.
//  Word boundary: bit_cnt == WIDTH-1. bit_cnt counts 0..WIDTH-1 and wraps to 0.
//  States:
//   SEARCH:
//    - bit-level hunt: every edge compare sr_next to COMMA.
//    - match -> bit_cnt<=0, com_cnt<=1; go ALIGN, or straight to ACTIVE if LOCK_COUNT==1.
//    - otherwise bit_cnt is don't-care; outputs hold valid_out=0, byte_strobe=0.
//   ALIGN:
//    - compare only at word boundary.
//    - sr_next==COMMA -> com_cnt++; when com_cnt+1==LOCK_COUNT go ACTIVE and set active=1 that edge.
//    - sr_next!=COMMA -> com_cnt<=0; go SEARCH.
//    - no strobes issued in ALIGN.
//   ACTIVE:
//    - at every word boundary: byte_strobe=1 for that one cycle and data_out<=sr_next.
//    - valid_out <= (sr_next != COMMA).
//    - data_out is loaded with the received symbol even when it is COM.
//    - between boundaries all outputs hold; byte_strobe=0.
//    - ACTIVE has no exit except reset; misaligned data is passed as received.
//  Latency: last bit of a symbol sampled at edge N -> data_out/valid_out/byte_strobe visible after edge N.
//   That is zero extra register stages beyond the output register.
//  First strobe after lock: the symbol following the LOCK_COUNT-th COM. The locking COM itself is not strobed.
//  com_cnt saturates at LOCK_COUNT; width = $clog2(LOCK_COUNT+1).
//  Reset asserted mid-symbol: immediate clear of everything. Partial symbol is discarded, not emitted.
// STRUCTURE
//  Shared package rx_phy_pkg: localparam COM = 8'hBC; enum/localparams ST_SEARCH=2'd0, ST_ALIGN=2'd1, ST_ACTIVE=2'd2.
//   The same COM constant is used by the TX parallel-to-serial block.
//  Single flat module: shift register + bit counter + 3-state FSM. No sub-module needed.
// TESTING
//  1 Reset: hold reset=0 while toggling data_in randomly -> all outputs 0; release, keep data_in=0 64 cycles -> active=0, no strobe.
//  2 Lock: 3 random bits then 4x 8'hBC -> active=1 on edge of 32nd COM bit; no byte_strobe before the 5th symbol.
//  3 Payload: after lock send BC,A5,3C,BC -> strobes every 8 clocks; data_out/valid_out = BC/0, A5/1, 3C/1, BC/0.
//  4 Broken alignment: BC,BC,BC,7E,BC,BC,BC,BC -> returns to SEARCH at 7E; active rises only after the final 4th consecutive BC.
//  5 Bit-slip hunt: prefix 5 junk bits containing no BC pattern -> lock on first real BC boundary; data bytes decode exactly.
//  6 Reset mid-operation: in ACTIVE assert reset=0 at bit 3 of symbol 55 -> outputs clear asynchronously; after release a full relock (4 COMs) is required.

Source files
------------

// File: rtl/rx_phy_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rx_phy_pkg
//  Description : Shared constants for the PHY lane serialiser/deserialiser
//                pair: comma symbol and receive-alignment state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package rx_phy_pkg;

    // Idle/alignment symbol; the TX parallel-to-serial block inserts the same value.
    localparam logic [7:0] COM = 8'hBC;

    // Receive alignment state encoding
    localparam logic [1:0] ST_SEARCH = 2'd0;
    localparam logic [1:0] ST_ALIGN  = 2'd1;
    localparam logic [1:0] ST_ACTIVE = 2'd2;

endpackage : rx_phy_pkg
`default_nettype wire

// File: rtl/serie_paralelo_rx.sv
`default_nettype none
// ============================================================================
//  Module      : serie_paralelo_rx
//  Description : Serial-to-parallel front end for one PHY_RX lane. Shifts in
//                one bit per clk_32f edge (MSB first), hunts for the comma
//                symbol at bit granularity, confirms alignment over
//                LOCK_COUNT consecutive word-aligned commas and then delivers
//                one {symbol, valid} word per WIDTH bit-times.
//  Revision    : 1.0 - initial release
// ============================================================================
module serie_paralelo_rx
    import rx_phy_pkg::*;
#(
    parameter int              WIDTH      = 8,
    parameter logic [WIDTH-1:0] COMMA     = WIDTH'(COM),
    parameter int              LOCK_COUNT = 4
) (
    input  logic             clk_32f,
    input  logic             reset,
    input  logic             data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             valid_out,
    output logic             byte_strobe,
    output logic             active
);

    localparam int             BCW         = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int             CCW         = $clog2(LOCK_COUNT + 1);
    localparam logic [BCW-1:0] LAST_BIT    = BCW'(WIDTH - 1);
    localparam logic [CCW-1:0] LOCK_TARGET = CCW'(LOCK_COUNT);
    // A single comma is enough to lock: the hunt goes straight to ACTIVE.
    localparam logic           SINGLE_COM  = (LOCK_COUNT == 1);

    // Only the WIDTH-1 most recent bits are kept: the bit that falls off the
    // top of the window on each shift is never looked at again.
    logic [WIDTH-2:0] sr;
    logic [WIDTH-1:0] sr_next;
    logic [BCW-1:0]   bit_cnt;
    logic [CCW-1:0]   com_cnt;
    logic [CCW-1:0]   com_cnt_inc;
    logic [1:0]       state;
    logic [1:0]       state_next;

    logic             boundary;
    logic             is_comma;
    logic             lock_reached;

    logic             hunt_hit;
    logic             align_hit;
    logic             align_miss;
    logic             enter_active;
    logic             emit_word;

    // Window including the bit being sampled this edge, so a symbol's last
    // bit is acted on in the same cycle it arrives.
    assign sr_next      = {sr, data_in};
    assign boundary     = (bit_cnt == LAST_BIT);
    assign is_comma     = (sr_next == COMMA);
    assign com_cnt_inc  = com_cnt + CCW'(1);
    assign lock_reached = (com_cnt_inc == LOCK_TARGET);

    // State register
    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            state <= ST_SEARCH;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: bit-level hunt, word-level confirmation, then sticky ACTIVE
    always_comb begin
        state_next = state;
        case (state)
            ST_SEARCH: begin
                if (is_comma) begin
                    state_next = SINGLE_COM ? ST_ACTIVE : ST_ALIGN;
                end
            end
            ST_ALIGN: begin
                if (boundary) begin
                    if (!is_comma) begin
                        state_next = ST_SEARCH;
                    end else if (lock_reached) begin
                        state_next = ST_ACTIVE;
                    end else begin
                        state_next = ST_ALIGN;
                    end
                end
            end
            ST_ACTIVE: begin
                state_next = ST_ACTIVE;
            end
            default: begin
                state_next = ST_SEARCH;
            end
        endcase
    end

    // Per-state control strobes that steer the counters and output register
    always_comb begin
        hunt_hit     = 1'b0;
        align_hit    = 1'b0;
        align_miss   = 1'b0;
        enter_active = 1'b0;
        emit_word    = 1'b0;
        case (state)
            ST_SEARCH: begin
                hunt_hit     = is_comma;
                enter_active = is_comma && SINGLE_COM;
            end
            ST_ALIGN: begin
                align_hit    = boundary && is_comma;
                align_miss   = boundary && !is_comma;
                enter_active = boundary && is_comma && lock_reached;
            end
            ST_ACTIVE: begin
                emit_word    = boundary;
            end
            default: begin
                hunt_hit     = 1'b0;
            end
        endcase
    end

    // Shift register, bit counter and comma counter
    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            sr      <= '0;
            bit_cnt <= '0;
            com_cnt <= '0;
        end else begin
            sr <= sr_next[WIDTH-2:0];

            // A bit-level comma hit defines the word grid: the next symbol
            // starts on the following edge.
            if (hunt_hit) begin
                bit_cnt <= '0;
            end else if (boundary) begin
                bit_cnt <= '0;
            end else begin
                bit_cnt <= bit_cnt + BCW'(1);
            end

            if (hunt_hit) begin
                com_cnt <= CCW'(1);
            end else if (align_miss) begin
                com_cnt <= '0;
            end else if (align_hit && (com_cnt < LOCK_TARGET)) begin
                com_cnt <= com_cnt_inc;
            end
        end
    end

    // Output register: one word per boundary once active; COM is delivered as idle
    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            data_out    <= '0;
            valid_out   <= 1'b0;
            byte_strobe <= 1'b0;
            active      <= 1'b0;
        end else begin
            byte_strobe <= emit_word;
            if (emit_word) begin
                data_out  <= sr_next;
                valid_out <= !is_comma;
            end
            if (enter_active) begin
                active <= 1'b1;
            end
        end
    end

endmodule : serie_paralelo_rx
`default_nettype wire

// File: tb/tb_serie_paralelo_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serie_paralelo_rx
//  Description : Self-checking bench for serie_paralelo_rx. A bit-history
//                reference model predicts every output on every edge, with
//                table-driven and hand-written sequences for lock, payload,
//                broken alignment, bit-slip and mid-symbol reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serie_paralelo_rx;

    localparam logic [7:0] BC   = 8'hBC;
    localparam int         LOCK = 4;

    logic       clk_32f = 1'b0;
    logic       reset   = 1'b0;
    logic       data_in = 1'b0;
    logic [7:0] data_out;
    logic       valid_out;
    logic       byte_strobe;
    logic       active;

    serie_paralelo_rx #(
        .WIDTH      (8),
        .COMMA      (BC),
        .LOCK_COUNT (LOCK)
    ) dut (
        .clk_32f     (clk_32f),
        .reset       (reset),
        .data_in     (data_in),
        .data_out    (data_out),
        .valid_out   (valid_out),
        .byte_strobe (byte_strobe),
        .active      (active)
    );

    always #5 clk_32f = ~clk_32f;

    int tests = 0;
    int fails = 0;
    int strobe_seen = 0;

    // Reference model: the bit stream since reset plus the position of the
    // comma that anchors the word grid.
    int         m_t;
    int         m_w;
    int         m_anchor;
    int         m_ncom;
    int         m_lock_t;
    bit         m_locked;
    bit         m_strobe;
    bit         m_valid;
    logic [7:0] m_data;

    typedef struct {
        logic [7:0] sym;
        logic       exp_active;
        logic       exp_strobe;
        logic [7:0] exp_data;
        logic       exp_valid;
    } vec_t;

    vec_t tbl [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_t      = 0;
        m_w      = 0;
        m_anchor = -1;
        m_ncom   = 0;
        m_lock_t = 0;
        m_locked = 0;
        m_strobe = 0;
        m_valid  = 0;
        m_data   = 8'h00;
    endtask

    // Advance the model by one sampled bit.
    task automatic model_step(input bit b);
        m_t++;
        m_w      = ((m_w << 1) | int'(b)) & 255;
        m_strobe = 0;
        if (!m_locked) begin
            if (m_anchor < 0) begin
                if (m_w == int'(BC)) begin
                    m_anchor = m_t;
                    m_ncom   = 1;
                    if (m_ncom == LOCK) begin
                        m_locked = 1;
                        m_lock_t = m_t;
                    end
                end
            end else if (((m_t - m_anchor) % 8) == 0) begin
                if (m_w == int'(BC)) begin
                    m_ncom++;
                    if (m_ncom == LOCK) begin
                        m_locked = 1;
                        m_lock_t = m_t;
                    end
                end else begin
                    m_anchor = -1;
                    m_ncom   = 0;
                end
            end
        end else if ((m_t > m_lock_t) && (((m_t - m_anchor) % 8) == 0)) begin
            m_strobe = 1;
            m_data   = 8'(m_w);
            m_valid  = (m_w != int'(BC));
        end
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic send_bit(input bit b);
        data_in = b;
        @(posedge clk_32f);
        model_step(b);
        #1;
        if (byte_strobe) strobe_seen++;
        check("cycle_model", {20'd0, data_out, valid_out, byte_strobe, active},
              {20'd0, m_data, m_valid, m_strobe, m_locked});
        @(negedge clk_32f);
    endtask

    task automatic send_sym(input logic [7:0] s);
        for (int i = 7; i >= 0; i--) begin
            send_bit(s[i]);
        end
    endtask

    // Hold reset with random serial data, outputs must stay cleared.
    task automatic do_reset(input int cycles);
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < cycles; i++) begin
            data_in = 1'($urandom);
            @(posedge clk_32f);
            #1;
            check("reset_outputs", {20'd0, data_out, valid_out, byte_strobe, active}, 32'd0);
            @(negedge clk_32f);
        end
        data_in = 1'b0;
        reset   = 1'b1;
    endtask

    initial begin
        logic [7:0] sym;
        logic [7:0] junk;
        int         njunk;

        tbl[0] = '{BC,    1'b0, 1'b0, 8'h00, 1'b0};
        tbl[1] = '{BC,    1'b0, 1'b0, 8'h00, 1'b0};
        tbl[2] = '{BC,    1'b0, 1'b0, 8'h00, 1'b0};
        tbl[3] = '{BC,    1'b1, 1'b0, 8'h00, 1'b0};
        tbl[4] = '{BC,    1'b1, 1'b1, BC,    1'b0};
        tbl[5] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 1'b1};
        tbl[6] = '{8'h3C, 1'b1, 1'b1, 8'h3C, 1'b1};
        tbl[7] = '{BC,    1'b1, 1'b1, BC,    1'b0};

        model_reset();
        @(negedge clk_32f);

        // Reset behaviour, then a long run of zeros must not lock
        do_reset(10);
        strobe_seen = 0;
        for (int i = 0; i < 64; i++) send_bit(1'b0);
        check("idle_active", {31'd0, active}, 32'd0);
        check("idle_strobes", strobe_seen, 0);

        // Lock after 3 random bits, then payload, table driven
        do_reset(3);
        for (int i = 0; i < 3; i++) send_bit(1'($urandom));
        for (int i = 0; i < 8; i++) begin
            send_sym(tbl[i].sym);
            check($sformatf("table_%0d", i),
                  {21'd0, active, byte_strobe, data_out, valid_out},
                  {21'd0, tbl[i].exp_active, tbl[i].exp_strobe, tbl[i].exp_data, tbl[i].exp_valid});
        end
        send_bit(1'b0);
        check("strobe_one_cycle", {31'd0, byte_strobe}, 32'd0);

        // Broken alignment: the 7E restarts the hunt
        do_reset(2);
        send_sym(BC); send_sym(BC); send_sym(BC);
        check("broken_pre", {31'd0, active}, 32'd0);
        send_sym(8'h7E);
        check("broken_7e", {31'd0, active}, 32'd0);
        send_sym(BC); send_sym(BC); send_sym(BC);
        check("broken_three", {31'd0, active}, 32'd0);
        send_sym(BC);
        check("broken_lock", {31'd0, active}, 32'd1);

        // Bit-slip hunt: 5 junk bits shift the word grid
        do_reset(2);
        junk = 8'b0001_0101;
        for (int i = 4; i >= 0; i--) send_bit(junk[i]);
        for (int i = 0; i < LOCK; i++) send_sym(BC);
        check("slip_lock", {31'd0, active}, 32'd1);
        send_sym(8'hA5);
        check("slip_a5", {22'd0, byte_strobe, data_out, valid_out}, {22'd0, 1'b1, 8'hA5, 1'b1});
        send_sym(8'h3C);
        check("slip_3c", {22'd0, byte_strobe, data_out, valid_out}, {22'd0, 1'b1, 8'h3C, 1'b1});
        send_sym(8'h5A);
        check("slip_5a", {22'd0, byte_strobe, data_out, valid_out}, {22'd0, 1'b1, 8'h5A, 1'b1});

        // Randomized payload against the model, then reset mid symbol 55
        do_reset(2);
        njunk = int'($urandom_range(0, 7));
        for (int i = 0; i < njunk; i++) send_bit(1'($urandom));
        for (int i = 0; i < LOCK; i++) send_sym(BC);
        strobe_seen = 0;
        for (int i = 0; i < 50; i++) begin
            sym = ($urandom_range(0, 3) == 0) ? BC : 8'($urandom);
            send_sym(sym);
        end
        check("rand_strobes", strobe_seen, 50);
        sym = 8'($urandom);
        for (int i = 7; i >= 5; i--) send_bit(sym[i]);
        reset = 1'b0;
        #1;
        check("async_clear", {20'd0, data_out, valid_out, byte_strobe, active}, 32'd0);
        do_reset(3);
        send_sym(BC); send_sym(BC); send_sym(BC);
        check("relock_pending", {31'd0, active}, 32'd0);
        send_sym(BC);
        check("relock_done", {31'd0, active}, 32'd1);
        send_sym(8'hC3);
        check("relock_data", {22'd0, byte_strobe, data_out, valid_out}, {22'd0, 1'b1, 8'hC3, 1'b1});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_serie_paralelo_rx
`default_nettype wire
